// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide scheduler that commits results to HI/LO after a fixed latency.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles after start; HI/LO update the first cycle busy is low.
// Backpressure: none; md/mt* ops arriving while busy are ignored and flagged on op_dropped.
module muldiv_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_dropped
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          commit;
  logic          is_md, is_mt, is_div;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_ok;

  // arithmetic datapath
  logic [63:0]   mul_a, mul_b, prod;
  logic          neg_a, neg_b;
  logic [31:0]   mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_ok;

  assign is_md  = (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
  assign is_mt  = (op == 4'd7) || (op == 4'd8);
  assign is_div = (op == 4'd3) || (op == 4'd4);

  // Read port for mfhi/mflo; always returns committed state, never the pending result.
  always_comb begin
    out = 32'd0;
    if (op == 4'd5)      out = hi;
    else if (op == 4'd6) out = lo;
  end

  // Next-state and start/commit decode.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (is_md && !cancel) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Product and quotient/remainder for the operation being issued this cycle.
  // Signed divide runs on magnitudes so 0x80000000 / -1 is well defined (wraps to 0x80000000).
  always_comb begin
    if (op == 4'd1) begin
      mul_a = {{32{rs[31]}}, rs};
      mul_b = {{32{rt[31]}}, rt};
    end else begin
      mul_a = {32'd0, rs};
      mul_b = {32'd0, rt};
    end
    prod    = mul_a * mul_b;

    neg_a   = (op == 4'd3) && rs[31];
    neg_b   = (op == 4'd3) && rt[31];
    mag_a   = neg_a ? (32'd0 - rs) : rs;
    mag_b   = neg_b ? (32'd0 - rt) : rt;
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag   = mag_a / divisor;
    r_mag   = mag_a % divisor;
    quo     = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem     = neg_a ? (32'd0 - r_mag) : r_mag;

    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
      res_ok = (rt != 32'd0);
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_ok = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pending result capture, latency counter, busy flag and protocol-violation pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_ok    <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      op_dropped <= 1'b0;
    end else begin
      op_dropped <= (state == RUN) && (is_md || is_mt) && !cancel;
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_ok <= res_ok;
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy    <= 1'b1;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        if (commit) busy <= 1'b0;
      end
    end
  end

  // Architectural HI/LO: commit of a pending result, or a direct mthi/mtlo write when idle.
  // Divide-by-zero leaves HI/LO untouched at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      if (pend_ok) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (state == IDLE && !cancel) begin
      if (op == 4'd7) hi <= rs;
      if (op == 4'd8) lo <= rs;
    end
  end

endmodule
